// File: rtl/snake_body_ctrl.sv
// Sequencer for the external snake-body direction shift register: fills it after reset,
// recirculates it, inserts head moves and walks the body once per frame. Option: SNAKE_WRAP_EN.
module snake_body_ctrl #(
   parameter int unsigned DEPTH    = 220,
   parameter int unsigned X_BITS   = 5,
   parameter int unsigned Y_BITS   = 4,
   parameter int unsigned FIELD_W  = 20,
   parameter int unsigned FIELD_H  = 11,
   parameter int unsigned INIT_LEN = 3,
   parameter int unsigned START_X  = 10,
   parameter int unsigned START_Y  = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic [1:0]                 sr_in,
   input  logic [1:0]                 sr_out,
   input  logic                       move_req,
   input  logic [1:0]                 move_dir,
   input  logic                       move_grow,
   output logic                       move_ack,
   output logic                       busy,
   output logic                       frame_start,
   output logic                       seg_valid,
   output logic                       seg_head,
   output logic [X_BITS-1:0]          seg_x,
   output logic [Y_BITS-1:0]          seg_y,
   output logic [X_BITS-1:0]          head_x,
   output logic [Y_BITS-1:0]          head_y,
   output logic [$clog2(DEPTH)-1:0]   length,
   output logic                       self_hit,
   output logic                       wall_hit
);

   localparam int unsigned PH_W  = $clog2(DEPTH);
   localparam int unsigned LEN_W = $clog2(DEPTH);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t             r_state, w_state_nxt;
   logic [PH_W-1:0]    r_fill, w_fill_nxt;
   logic [PH_W-1:0]    r_phase, w_phase_nxt;
   logic [X_BITS-1:0]  r_head_x, w_head_x_nxt, r_cur_x, w_cur_x_nxt;
   logic [Y_BITS-1:0]  r_head_y, w_head_y_nxt, r_cur_y, w_cur_y_nxt;
   logic [LEN_W-1:0]   r_len, w_len_nxt;
   logic               r_flag, w_flag_nxt;
   logic               r_self_hit, w_self_hit_nxt;

   logic               w_last, w_p0, w_valid, w_legal;
   logic [X_BITS-1:0]  w_mv_x, w_bk_x;
   logic [Y_BITS-1:0]  w_mv_y, w_bk_y;

   // Modular +/-1 on a field coordinate
   function automatic logic [X_BITS-1:0] x_step(input logic [X_BITS-1:0] x, input logic up);
      if (up) return (x == X_BITS'(FIELD_W-1)) ? '0 : x + X_BITS'(1);
      return (x == '0) ? X_BITS'(FIELD_W-1) : x - X_BITS'(1);
   endfunction

   function automatic logic [Y_BITS-1:0] y_step(input logic [Y_BITS-1:0] y, input logic up);
      if (up) return (y == Y_BITS'(FIELD_H-1)) ? '0 : y + Y_BITS'(1);
      return (y == '0) ? Y_BITS'(FIELD_H-1) : y - Y_BITS'(1);
   endfunction

   assign w_last  = (r_phase == PH_W'(DEPTH-1));
   assign w_p0    = (r_phase == '0);
   assign w_valid = (r_phase < r_len);

   // Candidate new head, and the walker step back along the entry leaving the register
   always_comb begin
      w_mv_x = r_head_x;
      w_mv_y = r_head_y;
      w_bk_x = r_cur_x;
      w_bk_y = r_cur_y;
      case (move_dir)
         2'd0:    w_mv_x = x_step(r_head_x, 1'b1);
         2'd1:    w_mv_y = y_step(r_head_y, 1'b1);
         2'd2:    w_mv_x = x_step(r_head_x, 1'b0);
         default: w_mv_y = y_step(r_head_y, 1'b0);
      endcase
      case (sr_out)
         2'd0:    w_bk_x = x_step(r_cur_x, 1'b0);
         2'd1:    w_bk_y = y_step(r_cur_y, 1'b0);
         2'd2:    w_bk_x = x_step(r_cur_x, 1'b1);
         default: w_bk_y = y_step(r_cur_y, 1'b1);
      endcase
   end

`ifdef SNAKE_WRAP_EN
   assign w_legal = 1'b1;
`else
   always_comb begin
      w_legal = 1'b1;
      case (move_dir)
         2'd0:    w_legal = (r_head_x != X_BITS'(FIELD_W-1));
         2'd1:    w_legal = (r_head_y != Y_BITS'(FIELD_H-1));
         2'd2:    w_legal = (r_head_x != '0);
         default: w_legal = (r_head_y != '0);
      endcase
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_INIT;
         r_fill     <= '0;
         r_phase    <= '0;
         r_head_x   <= X_BITS'(START_X);
         r_head_y   <= Y_BITS'(START_Y);
         r_cur_x    <= X_BITS'(START_X);
         r_cur_y    <= Y_BITS'(START_Y);
         r_len      <= LEN_W'(INIT_LEN);
         r_flag     <= 1'b0;
         r_self_hit <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fill     <= w_fill_nxt;
         r_phase    <= w_phase_nxt;
         r_head_x   <= w_head_x_nxt;
         r_head_y   <= w_head_y_nxt;
         r_cur_x    <= w_cur_x_nxt;
         r_cur_y    <= w_cur_y_nxt;
         r_len      <= w_len_nxt;
         r_flag     <= w_flag_nxt;
         r_self_hit <= w_self_hit_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_fill_nxt     = r_fill;
      w_phase_nxt    = r_phase;
      w_head_x_nxt   = r_head_x;
      w_head_y_nxt   = r_head_y;
      w_cur_x_nxt    = r_cur_x;
      w_cur_y_nxt    = r_cur_y;
      w_len_nxt      = r_len;
      w_flag_nxt     = r_flag;
      w_self_hit_nxt = r_self_hit;
      sr_in          = 2'd0;
      move_ack       = 1'b0;
      busy           = 1'b0;
      frame_start    = 1'b0;
      seg_valid      = 1'b0;
      seg_head       = 1'b0;
      seg_x          = '0;
      seg_y          = '0;
      wall_hit       = 1'b0;
      case (r_state)
         S_INIT: begin
            busy       = 1'b1;
            w_fill_nxt = r_fill + PH_W'(1);
            if (r_fill == PH_W'(DEPTH-1)) begin
               w_state_nxt = S_RUN;
               w_fill_nxt  = '0;
               w_phase_nxt = '0;
               w_cur_x_nxt = r_head_x;
               w_cur_y_nxt = r_head_y;
               w_flag_nxt  = 1'b0;
            end
         end
         S_RUN: begin
            sr_in       = sr_out;
            seg_x       = r_cur_x;
            seg_y       = r_cur_y;
            seg_valid   = w_valid;
            seg_head    = w_p0;
            frame_start = w_p0;
            w_phase_nxt = w_last ? '0 : r_phase + PH_W'(1);
            w_cur_x_nxt = w_bk_x;
            w_cur_y_nxt = w_bk_y;
            // Collision flag covers body indices 1..length-1 only
            w_flag_nxt  = r_flag | (w_valid && !w_p0 && r_cur_x == r_head_x && r_cur_y == r_head_y);
            if (w_p0) begin
               w_self_hit_nxt = r_flag;
               w_flag_nxt     = 1'b0;
            end
            if (w_last) begin
               w_cur_x_nxt = r_head_x;
               w_cur_y_nxt = r_head_y;
               if (move_req) begin
                  move_ack = 1'b1;
                  if (w_legal) begin
                     // Insert the move: this cycle becomes phase 0 of the new frame
                     sr_in          = move_dir;
                     w_head_x_nxt   = w_mv_x;
                     w_head_y_nxt   = w_mv_y;
                     frame_start    = 1'b1;
                     seg_valid      = 1'b1;
                     seg_head       = 1'b1;
                     seg_x          = w_mv_x;
                     seg_y          = w_mv_y;
                     w_phase_nxt    = PH_W'(1);
                     w_self_hit_nxt = r_flag;
                     w_flag_nxt     = 1'b0;
                     if (move_grow && r_len != LEN_W'(DEPTH-1))
                        w_len_nxt = r_len + LEN_W'(1);
                  end else begin
                     wall_hit = 1'b1;
                  end
               end
            end
         end
         default: w_state_nxt = S_INIT;
      endcase
   end

   assign head_x   = r_head_x;
   assign head_y   = r_head_y;
   assign length   = r_len;
   assign self_hit = r_self_hit;

endmodule
